// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the hardwired control sequencer: state codes, opcodes,
// register/ALU function codes, mux selects and the control output bundle.
package control_sequencer_pkg;

  localparam logic [2:0] T_INIT = 3'd0;

  typedef enum logic [2:0] {
    ST_INIT = T_INIT,
    ST_F0   = 3'd1,
    ST_F1   = 3'd2,
    ST_EX1  = 3'd3,
    ST_EX2  = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_LDI = 4'h0,
    OP_LDM = 4'h1,
    OP_ST  = 4'h2,
    OP_MOV = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_NOT = 4'h9,
    OP_LSL = 4'hA,
    OP_LSR = 4'hB,
    OP_BRA = 4'hC,
    OP_BEQ = 4'hD,
    OP_INC = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  // Register function codes, shared by IR, RegFile and ARF.
  localparam logic [1:0] FS_DEC  = 2'd0;
  localparam logic [1:0] FS_INC  = 2'd1;
  localparam logic [1:0] FS_LOAD = 2'd2;
  localparam logic [1:0] FS_CLR  = 2'd3;

  localparam logic [3:0] ALU_PASS_A = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b0001;
  localparam logic [3:0] ALU_NOT_B  = 4'b0011;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;
  localparam logic [3:0] ALU_XOR    = 4'b1001;
  localparam logic [3:0] ALU_LSL    = 4'b1010;
  localparam logic [3:0] ALU_LSR    = 4'b1011;

  localparam logic [1:0] MUXA_ALU = 2'd0;
  localparam logic [1:0] MUXA_MEM = 2'd1;
  localparam logic [1:0] MUXA_IMM = 2'd2;
  localparam logic [1:0] MUXB_IMM = 2'd2;
  localparam logic       MUXC_RF  = 1'b0;

  localparam logic [1:0] ARF_OUT_PC = 2'd0;
  localparam logic [1:0] ARF_OUT_AR = 2'd2;

  // Active-low ARF write enables; bit3 has no register behind it and stays high.
  localparam logic [3:0] ARF_WR_PC   = 4'b1110;
  localparam logic [3:0] ARF_WR_AR   = 4'b1101;
  localparam logic [3:0] ARF_WR_ALL  = 4'b1000;
  localparam logic [3:0] WR_NONE     = 4'b1111;

  typedef struct packed {
    logic       ir_en;
    logic       ir_nl_h;
    logic [1:0] ir_funsel;
    logic [3:0] rf_regsel;
    logic [1:0] rf_funsel;
    logic [1:0] rf_outasel;
    logic [1:0] rf_outbsel;
    logic [3:0] arf_regsel;
    logic [1:0] arf_funsel;
    logic [1:0] arf_outcsel;
    logic [1:0] arf_outdsel;
    logic [3:0] alu_funsel;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       mem_cs;
    logic       mem_wr;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    ir_en:       1'b0,
    ir_nl_h:     1'b0,
    ir_funsel:   FS_DEC,
    rf_regsel:   WR_NONE,
    rf_funsel:   FS_DEC,
    rf_outasel:  2'd0,
    rf_outbsel:  2'd0,
    arf_regsel:  WR_NONE,
    arf_funsel:  FS_DEC,
    arf_outcsel: 2'd0,
    arf_outdsel: ARF_OUT_PC,
    alu_funsel:  ALU_PASS_A,
    mux_a:       MUXA_ALU,
    mux_b:       2'd0,
    mux_c:       MUXC_RF,
    mem_cs:      1'b1,
    mem_wr:      1'b0,
    halted:      1'b0
  };

  // Active-low one-cold enable for RegFile register rd (bit0 = R1).
  function automatic logic [3:0] rf_wr_mask(input logic [1:0] rd);
    rf_wr_mask = ~(4'b0001 << rd);
  endfunction

  // Only the ALU-result opcodes (MOV..LSR) update the branch flag.
  function automatic logic latches_z(input opcode_t op);
    latches_z = (op >= OP_MOV) && (op <= OP_LSR);
  endfunction

endpackage

// File: rtl/control_sequencer_seq_decoder.sv
// Combinational decode of (state, instruction, Z flag) into the full
// datapath control bundle.
module seq_decoder
  import control_sequencer_pkg::*;
(
  input  state_t     state_i,
  input  logic [7:0] ir_hi_i,
  input  logic       z_i,
  output ctrl_t      ctrl_o
);

  opcode_t    op;
  logic [1:0] rd;
  logic [1:0] rs;

  assign op = opcode_t'(ir_hi_i[7:4]);
  assign rd = ir_hi_i[3:2];
  assign rs = ir_hi_i[1:0];

  always_comb begin
    // NOTE: the idle default covers every field before any branch, so no
    // path leaves an output unassigned and no latch is inferred.
    ctrl_o = CTRL_IDLE;
    unique case (state_i)
      ST_INIT: begin
        ctrl_o.rf_regsel  = 4'b0000;
        ctrl_o.rf_funsel  = FS_CLR;
        ctrl_o.arf_regsel = ARF_WR_ALL;
        ctrl_o.arf_funsel = FS_CLR;
        ctrl_o.ir_en      = 1'b1;
        ctrl_o.ir_funsel  = FS_CLR;
      end
      ST_F0, ST_F1: begin
        ctrl_o.mem_cs      = 1'b0;
        ctrl_o.arf_outdsel = ARF_OUT_PC;
        ctrl_o.ir_en       = 1'b1;
        ctrl_o.ir_funsel   = FS_LOAD;
        ctrl_o.ir_nl_h     = (state_i == ST_F1);
        ctrl_o.arf_regsel  = ARF_WR_PC;
        ctrl_o.arf_funsel  = FS_INC;
      end
      ST_EX1: begin
        unique case (op)
          OP_LDI: begin
            ctrl_o.mux_a     = MUXA_IMM;
            ctrl_o.rf_regsel = rf_wr_mask(rd);
            ctrl_o.rf_funsel = FS_LOAD;
          end
          OP_LDM, OP_ST: begin
            ctrl_o.mux_b      = MUXB_IMM;
            ctrl_o.arf_regsel = ARF_WR_AR;
            ctrl_o.arf_funsel = FS_LOAD;
          end
          OP_MOV, OP_NOT: begin
            ctrl_o.rf_outbsel = rs;
            ctrl_o.alu_funsel = (op == OP_MOV) ? ALU_PASS_B : ALU_NOT_B;
            ctrl_o.mux_a      = MUXA_ALU;
            ctrl_o.rf_regsel  = rf_wr_mask(rd);
            ctrl_o.rf_funsel  = FS_LOAD;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ctrl_o.rf_outasel = rd;
            ctrl_o.rf_outbsel = rs;
            ctrl_o.mux_c      = MUXC_RF;
            unique case (op)
              OP_ADD:  ctrl_o.alu_funsel = ALU_ADD;
              OP_SUB:  ctrl_o.alu_funsel = ALU_SUB;
              OP_AND:  ctrl_o.alu_funsel = ALU_AND;
              OP_OR:   ctrl_o.alu_funsel = ALU_OR;
              default: ctrl_o.alu_funsel = ALU_XOR;
            endcase
            ctrl_o.mux_a     = MUXA_ALU;
            ctrl_o.rf_regsel = rf_wr_mask(rd);
            ctrl_o.rf_funsel = FS_LOAD;
          end
          OP_LSL, OP_LSR: begin
            ctrl_o.rf_outasel = rd;
            ctrl_o.mux_c      = MUXC_RF;
            ctrl_o.alu_funsel = (op == OP_LSL) ? ALU_LSL : ALU_LSR;
            ctrl_o.mux_a      = MUXA_ALU;
            ctrl_o.rf_regsel  = rf_wr_mask(rd);
            ctrl_o.rf_funsel  = FS_LOAD;
          end
          OP_BRA, OP_BEQ: begin
            if (op == OP_BRA || z_i) begin
              ctrl_o.mux_b      = MUXB_IMM;
              ctrl_o.arf_regsel = ARF_WR_PC;
              ctrl_o.arf_funsel = FS_LOAD;
            end
          end
          OP_INC: begin
            ctrl_o.rf_regsel = rf_wr_mask(rd);
            ctrl_o.rf_funsel = FS_INC;
          end
          default: ;
        endcase
      end
      ST_EX2: begin
        // AR was loaded in EX1; the IR still holds the same instruction.
        ctrl_o.mem_cs      = 1'b0;
        ctrl_o.arf_outdsel = ARF_OUT_AR;
        if (op == OP_LDM) begin
          ctrl_o.mux_a     = MUXA_MEM;
          ctrl_o.rf_regsel = rf_wr_mask(rd);
          ctrl_o.rf_funsel = FS_LOAD;
        end else if (op == OP_ST) begin
          ctrl_o.rf_outasel = rd;
          ctrl_o.mux_c      = MUXC_RF;
          ctrl_o.alu_funsel = ALU_PASS_A;
          ctrl_o.mem_wr     = 1'b1;
        end
      end
      ST_HALT: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: state register and branch flag, with all datapath
// control decoded from the current state and IR.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] IRout,
  input  logic        ZeroFlag,
  output logic        IR_En,
  output logic        IR_NL_H,
  output logic [1:0]  IR_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [1:0]  RF_FunSel,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [3:0]  ARF_RegSel,
  output logic [1:0]  ARF_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic        Halted
);

  state_t  state_q, state_d;
  logic    z_q, z_d;
  ctrl_t   dec_ctrl;
  ctrl_t   ctrl;
  opcode_t op;
  logic    unused_imm;

  assign op         = opcode_t'(IRout[15:12]);
  assign unused_imm = ^IRout[7:0];

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    unique case (state_q)
      ST_INIT: state_d = ST_F0;
      ST_F0:   state_d = ST_F1;
      ST_F1:   state_d = ST_EX1;
      ST_EX1: begin
        if (op == OP_LDM || op == OP_ST) state_d = ST_EX2;
        else if (op == OP_HLT)           state_d = ST_HALT;
        else                             state_d = ST_F0;
        if (latches_z(op)) z_d = ZeroFlag;
      end
      ST_EX2:  state_d = ST_F0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state_q <= ST_INIT;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

  seq_decoder u_dec (
    .state_i (state_q),
    .ir_hi_i (IRout[15:8]),
    .z_i     (z_q),
    .ctrl_o  (dec_ctrl)
  );

  // Forcing idle while RST is high kills any in-flight write the moment reset
  // rises, not at the next clock edge.
  assign ctrl = RST ? CTRL_IDLE : dec_ctrl;

  assign IR_En       = ctrl.ir_en;
  assign IR_NL_H     = ctrl.ir_nl_h;
  assign IR_FunSel   = ctrl.ir_funsel;
  assign RF_RegSel   = ctrl.rf_regsel;
  assign RF_FunSel   = ctrl.rf_funsel;
  assign RF_OutASel  = ctrl.rf_outasel;
  assign RF_OutBSel  = ctrl.rf_outbsel;
  assign ARF_RegSel  = ctrl.arf_regsel;
  assign ARF_FunSel  = ctrl.arf_funsel;
  assign ARF_OutCSel = ctrl.arf_outcsel;
  assign ARF_OutDSel = ctrl.arf_outdsel;
  assign ALU_FunSel  = ctrl.alu_funsel;
  assign MuxASel     = ctrl.mux_a;
  assign MuxBSel     = ctrl.mux_b;
  assign MuxCSel     = ctrl.mux_c;
  assign Mem_CS      = ctrl.mem_cs;
  assign Mem_WR      = ctrl.mem_wr;
  assign Halted      = ctrl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: each cycle's expected control word is queued with the
// stimulus and compared against the DUT outputs mid-cycle.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic        CLK;
  logic        RST;
  logic [15:0] IRout;
  logic        ZeroFlag;
  logic        IR_En, IR_NL_H, MuxCSel, Mem_CS, Mem_WR, Halted;
  logic [1:0]  IR_FunSel, RF_FunSel, RF_OutASel, RF_OutBSel;
  logic [1:0]  ARF_FunSel, ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel;
  logic [3:0]  RF_RegSel, ARF_RegSel, ALU_FunSel;

  control_sequencer dut (
    .CLK(CLK), .RST(RST), .IRout(IRout), .ZeroFlag(ZeroFlag),
    .IR_En(IR_En), .IR_NL_H(IR_NL_H), .IR_FunSel(IR_FunSel),
    .RF_RegSel(RF_RegSel), .RF_FunSel(RF_FunSel),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
    .ARF_RegSel(ARF_RegSel), .ARF_FunSel(ARF_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ALU_FunSel(ALU_FunSel), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .Halted(Halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  ctrl_t obs;
  assign obs = {IR_En, IR_NL_H, IR_FunSel, RF_RegSel, RF_FunSel, RF_OutASel,
                RF_OutBSel, ARF_RegSel, ARF_FunSel, ARF_OutCSel, ARF_OutDSel,
                ALU_FunSel, MuxASel, MuxBSel, MuxCSel, Mem_CS, Mem_WR, Halted};

  typedef struct {
    string tag;
    ctrl_t c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic ctrl_t e_idle();
    ctrl_t e;
    e.ir_en = 1'b0;        e.ir_nl_h = 1'b0;      e.ir_funsel = 2'd0;
    e.rf_regsel = 4'b1111; e.rf_funsel = 2'd0;
    e.rf_outasel = 2'd0;   e.rf_outbsel = 2'd0;
    e.arf_regsel = 4'b1111; e.arf_funsel = 2'd0;
    e.arf_outcsel = 2'd0;  e.arf_outdsel = 2'd0;  e.alu_funsel = 4'd0;
    e.mux_a = 2'd0;        e.mux_b = 2'd0;        e.mux_c = 1'b0;
    e.mem_cs = 1'b1;       e.mem_wr = 1'b0;       e.halted = 1'b0;
    return e;
  endfunction

  function automatic ctrl_t e_init();
    ctrl_t e = e_idle();
    e.rf_regsel = 4'b0000;  e.rf_funsel = 2'd3;
    e.arf_regsel = 4'b1000; e.arf_funsel = 2'd3;
    e.ir_en = 1'b1;         e.ir_funsel = 2'd3;
    return e;
  endfunction

  function automatic ctrl_t e_fetch(input logic nl_h);
    ctrl_t e = e_idle();
    e.mem_cs = 1'b0; e.ir_en = 1'b1; e.ir_funsel = 2'd2; e.ir_nl_h = nl_h;
    e.arf_regsel = 4'b1110; e.arf_funsel = 2'd1;
    return e;
  endfunction

  function automatic ctrl_t e_alu(input logic [1:0] a, input logic [1:0] b,
                                  input logic [3:0] fn, input logic [3:0] wr);
    ctrl_t e = e_idle();
    e.rf_outasel = a; e.rf_outbsel = b; e.alu_funsel = fn;
    e.rf_regsel = wr; e.rf_funsel = 2'd2;
    return e;
  endfunction

  function automatic ctrl_t e_arf_load(input logic [3:0] wr);
    ctrl_t e = e_idle();
    e.mux_b = 2'd2; e.arf_regsel = wr; e.arf_funsel = 2'd2;
    return e;
  endfunction

  task automatic chk(input string tag, input ctrl_t exp);
    exp_t e;
    sb.push_back('{tag, exp});
    #1;
    e = sb.pop_front();
    checks++;
    assert (obs === e.c) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.c);
    end
  endtask

  task automatic step(input string tag, input ctrl_t exp);
    chk(tag, exp);
    @(negedge CLK);
  endtask

  task automatic run(input string name, input logic [15:0] ir, input logic zf,
                     input ctrl_t ex1, input bit has_ex2, input ctrl_t ex2);
    IRout    = ir;
    ZeroFlag = zf;
    step({name, "_f0"}, e_fetch(1'b0));
    step({name, "_f1"}, e_fetch(1'b1));
    step({name, "_ex1"}, ex1);
    if (has_ex2) step({name, "_ex2"}, ex2);
  endtask

  ctrl_t x, y;

  initial begin
    RST = 1'b1; IRout = 16'h0000; ZeroFlag = 1'b0;
    @(negedge CLK);
    step("reset_idle", e_idle());
    RST = 1'b0;
    step("init", e_init());

    x = e_idle(); x.mux_a = 2'd2; x.rf_regsel = 4'b1101; x.rf_funsel = 2'd2;
    run("ldi", 16'h042A, 1'b0, x, 0, x);
    run("add", 16'h4600, 1'b0, e_alu(2'd1, 2'd2, 4'b0100, 4'b1101), 0, x);

    y = e_idle(); y.mem_cs = 1'b0; y.arf_outdsel = 2'd2;
    y.mux_a = 2'd1; y.rf_regsel = 4'b1110; y.rf_funsel = 2'd2;
    run("ldm", 16'h1130, 1'b0, e_arf_load(4'b1101), 1, y);

    y = e_idle(); y.mem_cs = 1'b0; y.arf_outdsel = 2'd2;
    y.rf_outasel = 2'd3; y.mem_wr = 1'b1;
    run("st", 16'h2C40, 1'b0, e_arf_load(4'b1101), 1, y);

    run("sub_z1", 16'h5B00, 1'b1, e_alu(2'd2, 2'd3, 4'b0110, 4'b1011), 0, x);
    run("beq_taken", 16'hD010, 1'b0, e_arf_load(4'b1110), 0, x);
    run("beq_held", 16'hD010, 1'b0, e_arf_load(4'b1110), 0, x);
    x = e_idle(); x.rf_regsel = 4'b1011; x.rf_funsel = 2'd1;
    run("inc", 16'hE800, 1'b0, x, 0, x);
    run("and", 16'h6400, 1'b1, e_alu(2'd1, 2'd0, 4'b0111, 4'b1101), 0, x);
    run("or", 16'h7E00, 1'b1, e_alu(2'd3, 2'd2, 4'b1000, 4'b0111), 0, x);
    run("xor_z0", 16'h8100, 1'b0, e_alu(2'd0, 2'd1, 4'b1001, 4'b1110), 0, x);
    run("beq_not_taken", 16'hD020, 1'b1, e_idle(), 0, x);
    run("not", 16'h9700, 1'b0, e_alu(2'd0, 2'd3, 4'b0011, 4'b1101), 0, x);
    run("lsl", 16'hA800, 1'b0, e_alu(2'd2, 2'd0, 4'b1010, 4'b1011), 0, x);
    run("lsr", 16'hB000, 1'b0, e_alu(2'd0, 2'd0, 4'b1011, 4'b1110), 0, x);
    run("bra", 16'hC055, 1'b0, e_arf_load(4'b1110), 0, x);
    run("mov_z1", 16'h3600, 1'b1, e_alu(2'd0, 2'd2, 4'b0001, 4'b1101), 0, x);
    run("hlt", 16'hF000, 1'b0, e_idle(), 0, x);

    x = e_idle(); x.halted = 1'b1;
    for (int i = 0; i < 10; i++) step("halt_hold", x);

    // Asynchronous reset out of HALT, raised between clock edges.
    #3 RST = 1'b1;
    chk("rst_in_halt", e_idle());
    @(negedge CLK);
    chk("rst_held", e_idle());
    RST = 1'b0;
    step("init_after_halt", e_init());

    // Reset raised mid-F1 of a register write: nothing may be enabled.
    IRout = 16'h0C99; ZeroFlag = 1'b0;
    step("abort_f0", e_fetch(1'b0));
    chk("abort_f1", e_fetch(1'b1));
    #1 RST = 1'b1;
    chk("rst_mid_f1", e_idle());
    @(negedge CLK);
    RST = 1'b0;
    step("init_after_abort", e_init());

    // Z was set by MOV before the resets; it must now read as cleared.
    run("beq_after_rst", 16'hD010, 1'b0, e_idle(), 0, x);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
